// File: rtl/pipe_stage_mem_pkg.sv
// Shared EX/MEM pipeline types: the control word carried alongside operands,
// its field encodings, and the all-zero NOP control value.
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    JMP_NONE   = 2'b00,
    JMP_COND   = 2'b01,
    JMP_UNCOND = 2'b10
  } jmp_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SLT
  } aluins_e;

  typedef enum logic [1:0] {
    EXT_ZERO, EXT_SIGN, EXT_HI, EXT_PC
  } extsel_e;

  typedef struct packed {
    logic    wmem;
    logic    rmem;
    logic    wreg;
    logic    wpc;
    jmp_e    jmp;
    aluins_e aluins;
    extsel_e extsel;
  } ctrl_t;

  localparam int    CTRL_W   = $bits(ctrl_t);
  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/pipe_stage_mem_skid_slot.sv
// One payload+valid register. The control word is zeroed whenever the slot
// empties so an invalid slot can never present side-effecting control bits.
module pipe_skid_slot
  import cpu_pipe_pkg::*;
#(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_clr,
  input  ctrl_t         i_ctrl,
  input  logic [PW-1:0] i_data,
  output logic          o_valid,
  output ctrl_t         o_ctrl,
  output logic [PW-1:0] o_data
);

  logic          r_valid;
  ctrl_t         r_ctrl;
  logic [PW-1:0] r_data;

  // Payload loads only on i_load; a clear leaves the data bits untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= CTRL_NOP;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ctrl  <= i_ctrl;
      r_data  <= i_data;
    end else if (i_clr) begin
      r_valid <= 1'b0;
      r_ctrl  <= CTRL_NOP;
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_mem.sv
// EX->MEM stage register with valid/ready, flush and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN for a registered in_ready_o backed by one skid entry.
module pipe_stage_mem
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4,
  parameter int N_OPS  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  ctrl_t                   ctrl_i,
  input  logic [N_OPS*DATA_W-1:0] op_i,
  input  logic [N_OPS*REG_W-1:0]  src_i,
  input  logic [REG_W-1:0]        dest_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output ctrl_t                   ctrl_o,
  output logic [N_OPS*DATA_W-1:0] op_o,
  output logic [N_OPS*REG_W-1:0]  src_o,
  output logic [REG_W-1:0]        dest_o,
  output logic [CNT_W-1:0]        stall_cnt_o
);

  localparam int PW = N_OPS*DATA_W + N_OPS*REG_W + REG_W;

  logic          w_accept;
  logic          w_main_valid, w_main_load, w_main_clr;
  ctrl_t         w_main_ctrl, w_main_ctrl_d;
  logic [PW-1:0] w_main_data, w_main_data_d, w_in_data;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_in_data  = {op_i, src_i, dest_i};
  assign w_main_clr = flush_i || (w_main_valid && out_ready_i);

`ifdef PIPE_STAGE_SKID_EN
  logic          r_in_ready;
  logic          w_main_free, w_skid_load, w_skid_clr, w_skid_next;
  logic          w_skid_valid;
  ctrl_t         w_skid_ctrl;
  logic [PW-1:0] w_skid_data;

  assign in_ready_o    = r_in_ready;
  assign w_main_free   = !w_main_valid || out_ready_i;
  assign w_accept      = in_valid_i && r_in_ready && !flush_i;
  // The skid entry is older than any incoming beat, so it has priority into main.
  assign w_main_load   = !flush_i && w_main_free && (w_skid_valid || w_accept);
  assign w_main_ctrl_d = w_skid_valid ? w_skid_ctrl : ctrl_i;
  assign w_main_data_d = w_skid_valid ? w_skid_data : w_in_data;
  assign w_skid_load   = w_accept && !w_main_free;
  assign w_skid_clr    = flush_i || (w_skid_valid && w_main_free);
  assign w_skid_next   = !flush_i && (w_skid_valid ? !w_main_free : w_skid_load);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_in_ready <= 1'b0;
    else     r_in_ready <= !w_skid_next;
  end

  pipe_skid_slot #(.PW(PW)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_clr   (w_skid_clr),
    .i_ctrl  (ctrl_i),
    .i_data  (w_in_data),
    .o_valid (w_skid_valid),
    .o_ctrl  (w_skid_ctrl),
    .o_data  (w_skid_data)
  );
`else
  assign in_ready_o    = !w_main_valid || out_ready_i;
  assign w_accept      = in_valid_i && in_ready_o && !flush_i;
  assign w_main_load   = w_accept;
  assign w_main_ctrl_d = ctrl_i;
  assign w_main_data_d = w_in_data;
`endif

  pipe_skid_slot #(.PW(PW)) u_main (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_main_load),
    .i_clr   (w_main_clr),
    .i_ctrl  (w_main_ctrl_d),
    .i_data  (w_main_data_d),
    .o_valid (w_main_valid),
    .o_ctrl  (w_main_ctrl),
    .o_data  (w_main_data)
  );

  // A flushed held beat is dropped, so that cycle is not counted as a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (w_main_valid && !out_ready_i && !flush_i && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign out_valid_o            = w_main_valid;
  assign ctrl_o                 = w_main_ctrl;
  assign {op_o, src_o, dest_o}  = w_main_data;
  assign stall_cnt_o            = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_mem.sv
// Bench for pipe_stage_mem: directed steps plus random traffic checked against
// a queue model of the stage occupancy (depth 1, or 2 with PIPE_STAGE_SKID_EN).
module tb_pipe_stage_mem;
  import cpu_pipe_pkg::*;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [63:0] op;
    logic [7:0]  src;
    logic [3:0]  dest;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0;
  logic        in_ready_o, out_valid_o;
  ctrl_t       ctrl_i = '0, ctrl_o;
  logic [63:0] op_i = '0, op_o;
  logic [7:0]  src_i = '0, src_o;
  logic [3:0]  dest_i = '0, dest_o;
  logic [15:0] stall_cnt_o;

  pipe_stage_mem #(.DATA_W(32), .REG_W(4), .N_OPS(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .ctrl_i(ctrl_i), .op_i(op_i), .src_i(src_i),
    .dest_i(dest_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .ctrl_o(ctrl_o), .op_o(op_o), .src_o(src_o), .dest_o(dest_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  int    n_vec = 0, n_err = 0;
  beat_t q[$];
  beat_t last;
  int    mcnt;
  bit    m_rdy;

`ifdef PIPE_STAGE_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_ready();
    if (DEPTH == 1) return (q.size() == 0) || out_ready_i;
    return m_rdy;
  endfunction

  task automatic model_reset();
    q.delete();
    last  = '0;
    mcnt  = 0;
    m_rdy = 1'b0;
  endtask

  task automatic check_outputs();
    beat_t e;
    e = (q.size() > 0) ? q[0] : last;
    chk("out_valid", 64'(out_valid_o), 64'(q.size() > 0));
    chk("ctrl",      64'(ctrl_o),      (q.size() > 0) ? 64'(e.ctrl) : 64'd0);
    chk("op",        op_o,             e.op);
    chk("src",       64'(src_o),       64'(e.src));
    chk("dest",      64'(dest_o),      64'(e.dest));
    chk("in_ready",  64'(in_ready_o),  64'(exp_ready()));
    chk("stall_cnt", 64'(stall_cnt_o), 64'(mcnt));
  endtask

  task automatic drive(bit v, bit fl, bit ordy, beat_t b);
    in_valid_i  = v;
    flush_i     = fl;
    out_ready_i = ordy;
    ctrl_i      = b.ctrl;
    op_i        = b.op;
    src_i       = b.src;
    dest_i      = b.dest;
  endtask

  // Check the current cycle, advance the model by one edge, move to next negedge.
  task automatic tick();
    bit acc;
    #1;
    check_outputs();
    acc = in_valid_i && exp_ready() && !flush_i;
    if (q.size() > 0 && !out_ready_i && !flush_i && mcnt != 16'hFFFF) mcnt++;
    if (flush_i) q.delete();
    else begin
      if (q.size() > 0 && out_ready_i) void'(q.pop_front());
      if (acc) q.push_back({ctrl_i, op_i, src_i, dest_i});
    end
    if (q.size() > 0) last = q[0];
    m_rdy = (q.size() < DEPTH);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    model_reset();
    #1 check_outputs();
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  function automatic beat_t rnd_beat();
    beat_t b;
    logic [CTRL_W-1:0] c;
    c      = CTRL_W'($urandom);
    b.ctrl = ctrl_t'(c);
    b.op   = {$urandom, $urandom};
    b.src  = 8'($urandom);
    b.dest = 4'($urandom);
    return b;
  endfunction

  beat_t nb, ba, bb;

  initial begin
    nb = '0;
    model_reset();
    drive(0, 0, 1, nb);
    repeat (2) @(negedge clk);
    #1 check_outputs();
    rst = 1'b0;
    @(negedge clk);

    // Single beat, latency 1, then drains.
    ba = '0; ba.op = 64'h0000_0000_1234_5678; ba.dest = 4'h3; ba.ctrl.wreg = 1'b1;
    drive(1, 0, 1, ba); tick();
    drive(0, 0, 1, nb); #1;
    chk("t1_op0",  64'(op_o[31:0]), 64'h1234_5678);
    chk("t1_dest", 64'(dest_o), 64'h3);
    chk("t1_wreg", 64'(ctrl_o.wreg), 64'h1);
    tick(); tick();

    // Back-to-back beats 1..8 at full throughput.
    for (int i = 1; i <= 8; i++) begin
      ba = rnd_beat(); ba.op = 64'(i);
      drive(1, 0, 1, ba); tick();
    end
    drive(0, 0, 1, nb); repeat (3) tick();

    // Beat A held for 5 cycles while B is offered.
    pulse_reset();
    ba = rnd_beat(); bb = rnd_beat();
    drive(1, 0, 1, ba); tick();
    repeat (5) begin drive(1, 0, 0, bb); tick(); end
    #1 chk("t3_stall5", 64'(stall_cnt_o), 64'd5);
    repeat (3) begin drive(1, 0, 1, bb); tick(); end
    drive(0, 0, 1, nb); repeat (3) tick();

    // Flush while holding a wmem beat with a new beat offered.
    ba = rnd_beat(); ba.ctrl.wmem = 1'b1; bb = rnd_beat();
    drive(1, 0, 1, ba); tick();
    drive(1, 0, 0, bb); tick();
    drive(1, 1, 0, rnd_beat()); tick();
    #1 chk("t4_valid", 64'(out_valid_o), 64'd0);
    chk("t4_ctrl", 64'(ctrl_o), 64'd0);
    drive(0, 0, 1, nb); repeat (3) tick();

    // Randomized traffic.
    repeat (300) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) < 6, rnd_beat());
      tick();
    end

    // Reset pulsed mid-stall between clock edges.
    drive(1, 0, 0, rnd_beat()); tick(); tick();
    drive(0, 0, 0, nb);
    pulse_reset();
    drive(0, 0, 1, nb); repeat (3) tick();

    // Stall counter saturation.
    pulse_reset();
    drive(1, 0, 1, rnd_beat()); tick();
    drive(0, 0, 0, nb);
    repeat (65546) tick();
    #1 chk("sat_cnt", 64'(stall_cnt_o), 64'hFFFF);
    drive(0, 0, 1, nb); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
